// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared state encoding, I/O map defaults and address decode for
//            the mem_ctrl CPU-to-RAM front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    localparam int CPU_ADDR_W_DEFAULT = 9;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WR      = 2'd1;
    localparam state_t ST_RD_WAIT = 2'd2;
    localparam state_t ST_RD_DATA = 2'd3;

    localparam logic [CPU_ADDR_W_DEFAULT-1:0] IO_BASE          = 9'h100;
    localparam logic [CPU_ADDR_W_DEFAULT-1:0] LED_ADDR_DEFAULT = 9'h100;
    localparam logic [CPU_ADDR_W_DEFAULT-1:0] SW_ADDR_DEFAULT  = 9'h140;

    // The upper half of the CPU address space is I/O; a magnitude compare
    // against the base is the same as testing the top address bit.
    function automatic logic is_io(input logic [CPU_ADDR_W_DEFAULT-1:0] addr);
        return (addr >= IO_BASE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Single-outstanding load/store front end between the CPU and a
//            synchronous RAM, with LED/switch memory-mapped I/O.
// Options  : MEM_CTRL_ERR_EN adds rsp_err for unmapped I/O accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int CPU_ADDR_WIDTH = CPU_ADDR_W_DEFAULT,
    parameter logic [CPU_ADDR_WIDTH-1:0] LED_ADDR = LED_ADDR_DEFAULT,
    parameter logic [CPU_ADDR_WIDTH-1:0] SW_ADDR  = SW_ADDR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [ADDR_WIDTH-1:0]     ram_read_address,
    output logic [ADDR_WIDTH-1:0]     ram_write_address,
    output logic                      ram_write,
    output logic [DATA_WIDTH-1:0]     ram_din,
    input  logic [DATA_WIDTH-1:0]     ram_dout,
    input  logic [DATA_WIDTH-1:0]     sw_in,
    output logic [DATA_WIDTH-1:0]     led_out
`ifdef MEM_CTRL_ERR_EN
    ,
    output logic                      rsp_err
`endif
);

    state_t                    state;
    logic [CPU_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      sel_io_q;
    logic [DATA_WIDTH-1:0]     sw_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_io_q <= 1'b0;
            sw_q     <= '0;
            led_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        sel_io_q <= is_io(req_addr);
                        sw_q     <= sw_in;
                        if (req_write)
                            state <= ST_WR;
                        else if (is_io(req_addr))
                            state <= ST_RD_DATA;
                        else
                            state <= ST_RD_WAIT;
                    end
                end
                ST_WR: begin
                    if (addr_q == LED_ADDR)
                        led_out <= wdata_q;
                    state <= ST_IDLE;
                end
                ST_RD_WAIT: state <= ST_RD_DATA;
                ST_RD_DATA: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Every RAM/response output is decoded from state and capture registers,
    // so nothing on req_* reaches rsp_* or ram_* combinationally.
    assign req_ready         = (state == ST_IDLE);
    assign rsp_valid         = (state == ST_WR) || (state == ST_RD_DATA);
    assign ram_read_address  = addr_q[ADDR_WIDTH-1:0];
    assign ram_write_address = addr_q[ADDR_WIDTH-1:0];
    assign ram_din           = wdata_q;
    assign ram_write         = (state == ST_WR) && !sel_io_q;

    always_comb begin
        rsp_rdata = '0;
        if (state == ST_RD_DATA) begin
            if (!sel_io_q)
                rsp_rdata = ram_dout;
            else if (addr_q == SW_ADDR)
                rsp_rdata = sw_q;
        end
    end

`ifdef MEM_CTRL_ERR_EN
    always_comb begin
        rsp_err = 1'b0;
        if (sel_io_q) begin
            if (state == ST_WR)
                rsp_err = (addr_q != LED_ADDR);
            else if (state == ST_RD_DATA)
                rsp_err = (addr_q != SW_ADDR);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl with a behavioural RAM and a
//            word-level reference model of memory, LED and switch behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  ram_read_address;
    logic [7:0]  ram_write_address;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] sw_in;
    logic [15:0] led_out;
`ifdef MEM_CTRL_ERR_EN
    logic        rsp_err;
`endif

    mem_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout),
        .sw_in             (sw_in),
        .led_out           (led_out)
`ifdef MEM_CTRL_ERR_EN
        ,
        .rsp_err           (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle registered read.
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_write)
            ram_mem[ram_write_address] <= ram_din;
        ram_dout <= ram_mem[ram_read_address];
    end

    // Reference model state.
    logic [15:0] model_mem [256];
    logic [15:0] model_led;

    int n_vec = 0;
    int n_bad = 0;
    int rsp_count = 0;

    always @(negedge clk)
        if (rst_n === 1'b1 && rsp_valid === 1'b1)
            rsp_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_err_of(input logic wr, input logic [8:0] a);
        if (a < 9'h100) return 1'b0;
        return wr ? (a != 9'h100) : (a != 9'h140);
    endfunction

    function automatic logic [15:0] model_read(input logic [8:0] a, input logic [15:0] sw);
        if (a < 9'h100) return model_mem[a[7:0]];
        if (a == 9'h140) return sw;
        return 16'h0000;
    endfunction

    // One complete request: drive, wait for acceptance, find the response pulse
    // within a bounded window and compare it with the expected outcome.
    task automatic run_req(input string tag, input logic wr, input logic [8:0] a,
                           input logic [15:0] d, input logic [15:0] sw,
                           input logic [15:0] exp_rdata, input int exp_lat);
        int got;
        logic ram_tgt;
        ram_tgt = (a < 9'h100);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        sw_in     = sw;
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = ~d;
        sw_in     = ~sw;
        got = 0;
        for (int c = 1; c <= 4 && got == 0; c++) begin
            if (c > 1) @(negedge clk);
            check({tag, ".ram_write"}, {31'd0, ram_write}, {31'd0, (wr && ram_tgt && c == 1)});
            if (ram_write) begin
                check({tag, ".waddr"}, {24'd0, ram_write_address}, {24'd0, a[7:0]});
                check({tag, ".din"}, {16'd0, ram_din}, {16'd0, d});
            end
            if (rsp_valid) begin
                got = c;
                check({tag, ".rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rdata});
`ifdef MEM_CTRL_ERR_EN
                check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err_of(wr, a)});
`endif
            end
        end
        check({tag, ".latency"}, got, exp_lat);
        if (wr && ram_tgt) model_mem[a[7:0]] = d;
        if (wr && a == 9'h100) model_led = d;
        @(negedge clk);
        check({tag, ".rsp_done"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".idle"}, {31'd0, req_ready}, 32'd1);
        check({tag, ".led"}, {16'd0, led_out}, {16'd0, model_led});
    endtask

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int base;
        logic        wr;
        logic [8:0]  a;
        logic [15:0] d, sw, exp;
        int          lat;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        model_led = 16'h0000;

        tbl[0]  = '{1'b1, 9'h012, 16'h00A5, 16'h0000, 16'h0000, 1};
        tbl[1]  = '{1'b0, 9'h012, 16'h0000, 16'h0000, 16'h00A5, 2};
        tbl[2]  = '{1'b0, 9'h140, 16'h0000, 16'h3C3C, 16'h3C3C, 1};
        tbl[3]  = '{1'b1, 9'h100, 16'hBEEF, 16'h0000, 16'h0000, 1};
        tbl[4]  = '{1'b1, 9'h0FF, 16'hFFFF, 16'h0000, 16'h0000, 1};
        tbl[5]  = '{1'b0, 9'h1FF, 16'h0000, 16'h7777, 16'h0000, 1};
        tbl[6]  = '{1'b1, 9'h1FF, 16'h1234, 16'h0000, 16'h0000, 1};
        tbl[7]  = '{1'b0, 9'h0FF, 16'h0000, 16'h0000, 16'hFFFF, 2};
        tbl[8]  = '{1'b0, 9'h100, 16'h0000, 16'hAAAA, 16'h0000, 1};
        tbl[9]  = '{1'b1, 9'h140, 16'h5555, 16'h0000, 16'h0000, 1};
        tbl[10] = '{1'b0, 9'h000, 16'h0000, 16'h0000, 16'h0000, 2};
        tbl[11] = '{1'b1, 9'h000, 16'h8001, 16'h0000, 16'h0000, 1};
        tbl[12] = '{1'b0, 9'h000, 16'h0000, 16'h0000, 16'h8001, 2};
        tbl[13] = '{1'b0, 9'h012, 16'h0000, 16'hFFFF, 16'h00A5, 2};

        // Reset held across two edges with a request pending.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h100;
        req_wdata = 16'hFFFF;
        sw_in     = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset.ready", {31'd0, req_ready}, 32'd1);
            check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("reset.rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
            check("reset.led", {16'd0, led_out}, 32'd0);
            check("reset.ram_write", {31'd0, ram_write}, 32'd0);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 14; i++)
            run_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                    tbl[i].sw, tbl[i].exp_rdata, tbl[i].exp_lat);

        // Reset during RD_WAIT drops the response and clears the LED register.
        base = rsp_count;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h012;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        model_led = 16'h0000;
        @(negedge clk);
        check("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst.ready", {31'd0, req_ready}, 32'd1);
        check("midrst.led", {16'd0, led_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst.no_rsp", rsp_count - base, 0);
        run_req("midrst.reload", 1'b0, 9'h012, 16'h0, 16'h0, 16'h00A5, 2);

        // Request held high across a RAM load: the follow-on store is taken
        // exactly once, only after the load response.
        base = rsp_count;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h0FF;
        @(negedge clk);
        req_write = 1'b1; req_addr = 9'h030; req_wdata = 16'h1234;
        check("bp.ready_rdwait", {31'd0, req_ready}, 32'd0);
        check("bp.no_write_rdwait", {31'd0, ram_write}, 32'd0);
        @(negedge clk);
        check("bp.ready_rddata", {31'd0, req_ready}, 32'd0);
        check("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp.rdata", {16'd0, rsp_rdata}, 32'h0000FFFF);
        @(negedge clk);
        check("bp.ready_idle", {31'd0, req_ready}, 32'd1);
        check("bp.idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp.ack", {31'd0, rsp_valid}, 32'd1);
        check("bp.ram_write", {31'd0, ram_write}, 32'd1);
        check("bp.waddr", {24'd0, ram_write_address}, 32'h30);
        @(negedge clk);
        check("bp.rsp_count", rsp_count - base, 2);
        check("bp.ready_after", {31'd0, req_ready}, 32'd1);
        model_mem[8'h30] = 16'h1234;
        run_req("bp.readback", 1'b0, 9'h030, 16'h0, 16'h0, 16'h1234, 2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 9'h100;
                1:       a = 9'h140;
                2:       a = 9'h1FF;
                3:       a = 9'($urandom_range(9'h100, 9'h1FF));
                4:       a = 9'($urandom_range(0, 255));
                default: a = 9'($urandom_range(0, 15));
            endcase
            d   = 16'($urandom);
            sw  = 16'($urandom);
            exp = wr ? 16'h0000 : model_read(a, sw);
            lat = (wr || a >= 9'h100) ? 1 : 2;
            run_req($sformatf("rnd%0d", i), wr, a, d, sw, exp, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
